alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational `alu` instance between two requesters: requester 0 is the integer execute stage and requester 1 is the address/branch-compare unit.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Operands are registered before they drive the ALU, and the ALU result plus flags are registered before they return to the requester.
- Sits between the decode/issue logic and the `alu` instance in the CPU datapath.

Parameters:
- DATA_WIDTH, 64, operand and result width; matches the `alu` DATA_WIDTH.
- TAG_WIDTH, 4, width of the opaque requester tag returned unchanged with the result.
- CNT_WIDTH, 16, width of each per-requester completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester request accepted this cycle.
- req_in1  input  2*DATA_WIDTH  operand 1; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_in2  input  2*DATA_WIDTH  operand 2; sliced as for req_in1.
- req_func3  input  2*4  func3 per requester, sliced by 4.
- req_func7  input  2*4  func7 per requester, sliced by 4.
- req_tag  input  2*TAG_WIDTH  tag per requester.
- alu_in1, alu_in2  output  DATA_WIDTH  operands driven to the ALU.
- alu_func3, alu_func7  output  4  opcode fields driven to the ALU.
- alu_C  input  DATA_WIDTH  ALU result.
- alu_flags  input  4  {zero, cout, overflow, sign} from the ALU.
- rsp_valid  output  2  response valid, one-hot to the owning requester.
- rsp_ready  input  2  per-requester response accept.
- rsp_C  output  DATA_WIDTH  registered result.
- rsp_flags  output  4  registered {zero, cout, overflow, sign}.
- rsp_tag  output  TAG_WIDTH  tag of the completed operation.
- busy  output  1  high whenever the FSM is not in IDLE.
- op_count0, op_count1  output  CNT_WIDTH  completed operations per requester.

Behaviour:
- States: IDLE, ISSUE, RESP. Reset state is IDLE.
- Reset values:
  - req_ready = 0, rsp_valid = 0.
  - rsp_C, rsp_flags, rsp_tag = 0.
  - alu_in1/in2/func3/func7 = 0.
  - busy = 0, both counters = 0.
  - priority pointer = requester 0.
- IDLE:
  - The grant is combinational: if exactly one req_valid bit is set, that requester wins. If both are set, the requester named by the priority pointer wins.
  - req_ready equals the grant vector; at most one bit is ever high.
  - On a grant, capture that requester's in1, in2, func3, func7 and tag into operand registers, record the owner, flip the priority pointer to the other requester, and go to ISSUE.
  - If no request is valid, stay in IDLE and leave the pointer unchanged.
- ISSUE (exactly one cycle):
  - alu_* outputs are driven from the operand registers.
  - At the clock edge, capture alu_C into rsp_C, alu_flags into rsp_flags and the stored tag into rsp_tag, then go to RESP.
- RESP:
  - rsp_valid[owner] = 1 and the other bit = 0.
  - rsp_C, rsp_flags and rsp_tag are held stable until the handshake.
  - When rsp_ready[owner] is high, increment op_count[owner] (wraps at 2^CNT_WIDTH) and go to IDLE.
  - rsp_ready from the non-owner is ignored.
- Outside ISSUE, alu_* outputs are 0, so the ALU inputs do not toggle.
- req_ready is 0 in ISSUE and RESP, so a new request is never accepted while an operation is outstanding.
- Timing:
  - Minimum latency from accept to rsp_valid is 2 cycles.
  - Maximum throughput is one operation per 3 cycles.
  - The response is held indefinitely under backpressure.
- Fairness: with both requesters continuously valid, grants strictly alternate, so neither requester waits more than one operation.
- Requesters may drop req_valid before acceptance. The arbiter samples operands only in the grant cycle.
- When rst_n is asserted mid-operation, reset acts immediately: the FSM returns to IDLE, an in-flight result is discarded and rsp_valid drops asynchronously. The counters and pointer reset.
- The arbiter passes func3/func7 through unchanged and does not decode them.

Test Plan:
- Single op: requester 0 sends in1=5, in2=3, func3=0, func7=0, tag=2.
  - req_ready[0] is high in the accept cycle.
  - rsp_valid=2'b01 appears two cycles later with rsp_C=8 and tag=2.
  - op_count0 becomes 1 after the handshake.
- Contention: both requesters valid from reset with ops 0 to 3.
  - Grant order is 0,1,0,1.
  - Each response is routed to the correct requester with the correct rsp_C and tag.
- Backpressure: hold rsp_ready[1]=0 for 5 cycles after rsp_valid[1] rises.
  - rsp_C, rsp_flags and rsp_tag stay stable.
  - req_ready stays 0 while requester 0 is valid.
  - Requester 0 is granted in the cycle after the handshake completes.
- Flags: requester 1 sends in1=64'h7FFF_FFFF_FFFF_FFFF, in2=1, add.
  - rsp_C=64'h8000_0000_0000_0000.
  - rsp_flags shows overflow=1 and sign=1, matching the ALU outputs.
- Reset mid-op: assert rst_n=0 while in ISSUE or RESP.
  - All outputs go to their reset values immediately.
  - No counter increments.
  - The first request after reset is accepted normally.
- Counter wrap: with CNT_WIDTH=4, complete 17 ops on requester 0.
  - op_count0=1 and op_count1=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between the integer execute
// stage (requester 0) and the address/branch-compare unit (requester 1).
// Requests are granted round-robin. The winning operands are registered, shown
// to the ALU for one cycle, and the result is registered and held until the
// owning requester takes it.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [2*DATA_WIDTH-1:0]   req_in1,
    input  logic [2*DATA_WIDTH-1:0]   req_in2,
    input  logic [7:0]                req_func3,
    input  logic [7:0]                req_func7,
    input  logic [2*TAG_WIDTH-1:0]    req_tag,
    output logic [DATA_WIDTH-1:0]     alu_in1,
    output logic [DATA_WIDTH-1:0]     alu_in2,
    output logic [3:0]                alu_func3,
    output logic [3:0]                alu_func7,
    input  logic [DATA_WIDTH-1:0]     alu_C,
    input  logic [3:0]                alu_flags,
    output logic [1:0]                rsp_valid,
    input  logic [1:0]                rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_C,
    output logic [3:0]                rsp_flags,
    output logic [TAG_WIDTH-1:0]      rsp_tag,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      op_count0,
    output logic [CNT_WIDTH-1:0]      op_count1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                 state;
    logic                   ptr;
    logic                   owner;
    logic [DATA_WIDTH-1:0]  op_in1;
    logic [DATA_WIDTH-1:0]  op_in2;
    logic [3:0]             op_func3;
    logic [3:0]             op_func7;
    logic [TAG_WIDTH-1:0]   op_tag;

    logic [1:0]             grant;
    logic                   sel;
    logic [DATA_WIDTH-1:0]  sel_in1;
    logic [DATA_WIDTH-1:0]  sel_in2;
    logic [3:0]             sel_func3;
    logic [3:0]             sel_func7;
    logic [TAG_WIDTH-1:0]   sel_tag;

    // Grant only in IDLE (and never while reset is held); a tie goes to the pointer.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE && rst_n) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel = grant[1];

    // Pick the winning requester's operand slices for capture.
    always_comb begin
        sel_in1   = sel ? req_in1[2*DATA_WIDTH-1:DATA_WIDTH] : req_in1[DATA_WIDTH-1:0];
        sel_in2   = sel ? req_in2[2*DATA_WIDTH-1:DATA_WIDTH] : req_in2[DATA_WIDTH-1:0];
        sel_func3 = sel ? req_func3[7:4] : req_func3[3:0];
        sel_func7 = sel ? req_func7[7:4] : req_func7[3:0];
        sel_tag   = sel ? req_tag[2*TAG_WIDTH-1:TAG_WIDTH] : req_tag[TAG_WIDTH-1:0];
    end

    assign req_ready = grant;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP) ? {owner, ~owner} : 2'b00;

    // The ALU only sees operands during ISSUE so its inputs stay quiet otherwise.
    assign alu_in1   = (state == ISSUE) ? op_in1   : '0;
    assign alu_in2   = (state == ISSUE) ? op_in2   : '0;
    assign alu_func3 = (state == ISSUE) ? op_func3 : '0;
    assign alu_func7 = (state == ISSUE) ? op_func7 : '0;

    // Arbitration FSM: capture on grant, sample the ALU in ISSUE, hold in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            op_in1    <= '0;
            op_in2    <= '0;
            op_func3  <= '0;
            op_func7  <= '0;
            op_tag    <= '0;
            rsp_C     <= '0;
            rsp_flags <= '0;
            rsp_tag   <= '0;
            op_count0 <= '0;
            op_count1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        op_in1   <= sel_in1;
                        op_in2   <= sel_in2;
                        op_func3 <= sel_func3;
                        op_func7 <= sel_func7;
                        op_tag   <= sel_tag;
                        owner    <= sel;
                        ptr      <= ~sel;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_C     <= alu_C;
                    rsp_flags <= alu_flags;
                    rsp_tag   <= op_tag;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        if (owner) begin
                            op_count1 <= op_count1 + CNT_WIDTH'(1);
                        end else begin
                            op_count0 <= op_count0 + CNT_WIDTH'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the shared-ALU arbiter. A small
// behavioural ALU stands in for the real one.
module tb_alu_share_arbiter;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [127:0]  req_in1;
    logic [127:0]  req_in2;
    logic [7:0]    req_func3;
    logic [7:0]    req_func7;
    logic [7:0]    req_tag;
    logic [63:0]   alu_in1;
    logic [63:0]   alu_in2;
    logic [3:0]    alu_func3;
    logic [3:0]    alu_func7;
    logic [63:0]   alu_C;
    logic [3:0]    alu_flags;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [63:0]   rsp_C;
    logic [3:0]    rsp_flags;
    logic [3:0]    rsp_tag;
    logic          busy;
    logic [3:0]    op_count0;
    logic [3:0]    op_count1;

    int tests_run;
    int tests_failed;

    alu_share_arbiter #(
        .DATA_WIDTH(64),
        .TAG_WIDTH (4),
        .CNT_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_func3 (req_func3),
        .req_func7 (req_func7),
        .req_tag   (req_tag),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_func3 (alu_func3),
        .alu_func7 (alu_func7),
        .alu_C     (alu_C),
        .alu_flags (alu_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_C     (rsp_C),
        .rsp_flags (rsp_flags),
        .rsp_tag   (rsp_tag),
        .busy      (busy),
        .op_count0 (op_count0),
        .op_count1 (op_count1)
    );

    // Behavioural ALU: returns {zero, cout, overflow, sign, result}.
    function automatic logic [67:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [3:0] f3, input logic [3:0] f7);
        logic [64:0] wide;
        logic [63:0] c;
        logic        cout;
        logic        ovf;
        wide = '0;
        c    = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        case (f3)
            4'd0: begin
                if (f7 == 4'd0) begin
                    wide = {1'b0, a} + {1'b0, b};
                    c    = wide[63:0];
                    cout = wide[64];
                    ovf  = (a[63] == b[63]) && (c[63] != a[63]);
                end else begin
                    wide = {1'b0, a} - {1'b0, b};
                    c    = wide[63:0];
                    cout = wide[64];
                    ovf  = (a[63] != b[63]) && (c[63] != a[63]);
                end
            end
            4'd1:    c = a & b;
            4'd2:    c = a | b;
            4'd3:    c = a ^ b;
            default: c = a;
        endcase
        return {(c == 64'd0), cout, ovf, c[63], c};
    endfunction

    // The ALU the arbiter drives is purely combinational.
    always_comb begin
        {alu_flags, alu_C} = alu_model(alu_in1, alu_in2, alu_func3, alu_func7);
    end

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Load one requester's operand slices.
    task automatic set_req(input int r, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] f3, input logic [3:0] f7, input logic [3:0] tag);
        if (r == 0) begin
            req_in1[63:0] = a;  req_in2[63:0] = b;
            req_func3[3:0] = f3; req_func7[3:0] = f7; req_tag[3:0] = tag;
        end else begin
            req_in1[127:64] = a; req_in2[127:64] = b;
            req_func3[7:4] = f3; req_func7[7:4] = f7; req_tag[7:4] = tag;
        end
    endtask

    // Hold reset for two cycles and leave just after a falling edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Issue one op on requester r and take its response; reports what came back.
    task automatic run_op(input int r, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] f3, input logic [3:0] f7, input logic [3:0] tag,
                          output logic [63:0] c, output logic [3:0] flags,
                          output logic [3:0] tag_out, output int lat, output bit timed_out);
        int waited;
        timed_out = 1'b0;
        c = '0; flags = '0; tag_out = '0; lat = 0;
        set_req(r, a, b, f3, f7, tag);
        req_valid[r] = 1'b1;
        #1;
        waited = 0;
        while (!req_ready[r] && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        if (!req_ready[r]) begin
            timed_out = 1'b1;
            req_valid[r] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[r] = 1'b0;
        #1;
        lat = 1;
        while (!rsp_valid[r] && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        if (!rsp_valid[r]) begin
            timed_out = 1'b1;
            return;
        end
        c = rsp_C; flags = rsp_flags; tag_out = rsp_tag;
        rsp_ready[r] = 1'b1;
        @(negedge clk);
        rsp_ready[r] = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b want 00", req_ready); end
        tests_run++; if (rsp_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        tests_run++; if ({rsp_C, rsp_flags, rsp_tag} !== 72'd0) begin tests_failed++; $display("[TB] FAIL reset_rsp_data: got %h/%h/%h want 0", rsp_C, rsp_flags, rsp_tag); end
        tests_run++; if ({alu_in1, alu_in2, alu_func3, alu_func7} !== 136'd0) begin tests_failed++; $display("[TB] FAIL reset_alu: got %h/%h want 0", alu_in1, alu_in2); end
        tests_run++; if ({busy, op_count0, op_count1} !== 9'd0) begin tests_failed++; $display("[TB] FAIL reset_state: busy=%b cnt0=%0d cnt1=%0d want 0", busy, op_count0, op_count1); end
        do_reset();
    endtask

    task automatic test_single_op();
        do_reset();
        set_req(0, 64'd5, 64'd3, 4'd0, 4'd0, 4'd2);
        req_valid = 2'b01;
        #1;
        tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("[TB] FAIL single_accept: req_ready=%b want 01", req_ready); end
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00;
        #1;
        tests_run++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL single_issue: busy=%b rsp_valid=%b want 1/00", busy, rsp_valid); end
        tests_run++; if (alu_in1 !== 64'd5 || alu_in2 !== 64'd3) begin tests_failed++; $display("[TB] FAIL single_alu_in: got %0d/%0d want 5/3", alu_in1, alu_in2); end
        @(negedge clk); #1;
        tests_run++; if (rsp_valid !== 2'b01) begin tests_failed++; $display("[TB] FAIL single_rsp_valid: got %b want 01", rsp_valid); end
        tests_run++; if (rsp_C !== 64'd8 || rsp_tag !== 4'd2 || rsp_flags !== 4'b0000) begin tests_failed++; $display("[TB] FAIL single_rsp: C=%0d tag=%0d flags=%b want 8/2/0000", rsp_C, rsp_tag, rsp_flags); end
        tests_run++; if (alu_in1 !== 64'd0 || op_count0 !== 4'd0) begin tests_failed++; $display("[TB] FAIL single_idle_alu: alu_in1=%0d cnt0=%0d want 0/0", alu_in1, op_count0); end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        tests_run++; if (op_count0 !== 4'd1 || busy !== 1'b0 || rsp_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL single_done: cnt0=%0d busy=%b rsp_valid=%b want 1/0/00", op_count0, busy, rsp_valid); end
    endtask

    task automatic test_contention();
        int waited;
        int who;
        do_reset();
        set_req(0, 64'd100, 64'd0, 4'd0, 4'd0, 4'd0);
        set_req(1, 64'd101, 64'd1, 4'd0, 4'd0, 4'd1);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            who = k % 2;
            waited = 0;
            while (req_ready == 2'b00 && waited < 10) begin @(negedge clk); #1; waited++; end
            tests_run++; if (req_ready !== (who ? 2'b10 : 2'b01)) begin tests_failed++; $display("[TB] FAIL contention_grant%0d: req_ready=%b want requester %0d", k, req_ready, who); end
            @(posedge clk); @(negedge clk);
            if (k + 2 < 4) set_req(who, 64'(100 + k + 2), 64'(k + 2), 4'd0, 4'd0, 4'(k + 2));
            else req_valid[who] = 1'b0;
            #1;
            waited = 0;
            while (rsp_valid == 2'b00 && waited < 10) begin @(negedge clk); #1; waited++; end
            tests_run++; if (rsp_valid !== (who ? 2'b10 : 2'b01)) begin tests_failed++; $display("[TB] FAIL contention_route%0d: rsp_valid=%b want requester %0d", k, rsp_valid, who); end
            tests_run++; if (rsp_C !== 64'(100 + 2 * k) || rsp_tag !== 4'(k)) begin tests_failed++; $display("[TB] FAIL contention_data%0d: C=%0d tag=%0d want %0d/%0d", k, rsp_C, rsp_tag, 100 + 2 * k, k); end
            @(negedge clk); #1;
        end
        rsp_ready = 2'b00;
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        int waited;
        do_reset();
        set_req(1, 64'h1234, 64'h00FF, 4'd3, 4'd0, 4'd9);
        set_req(0, 64'd7, 64'd7, 4'd0, 4'd0, 4'd4);
        req_valid = 2'b10;
        #1;
        tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("[TB] FAIL bp_accept: req_ready=%b want 10", req_ready); end
        @(posedge clk); @(negedge clk);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        #1;
        waited = 0;
        while (!rsp_valid[1] && waited < 10) begin @(negedge clk); #1; waited++; end
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (rsp_valid !== 2'b10 || req_ready !== 2'b00) begin tests_failed++; $display("[TB] FAIL bp_hold%0d: rsp_valid=%b req_ready=%b want 10/00", i, rsp_valid, req_ready); end
            tests_run++; if (rsp_C !== 64'h12CB || rsp_flags !== 4'b0000 || rsp_tag !== 4'd9) begin tests_failed++; $display("[TB] FAIL bp_stable%0d: C=%h flags=%b tag=%0d want 12cb/0000/9", i, rsp_C, rsp_flags, rsp_tag); end
            @(negedge clk); #1;
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("[TB] FAIL bp_next_grant: req_ready=%b want 01", req_ready); end
        tests_run++; if (op_count1 !== 4'd1 || op_count0 !== 4'd0) begin tests_failed++; $display("[TB] FAIL bp_counts: cnt0=%0d cnt1=%0d want 0/1", op_count0, op_count1); end
        req_valid = 2'b00;
    endtask

    task automatic test_flags();
        logic [63:0] c;
        logic [3:0]  f;
        logic [3:0]  t;
        int          lat;
        bit          to;
        do_reset();
        run_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 4'd0, 4'd5, c, f, t, lat, to);
        tests_run++; if (to !== 1'b0 || lat !== 2) begin tests_failed++; $display("[TB] FAIL flags_latency: timeout=%b latency=%0d want 0/2", to, lat); end
        tests_run++; if (c !== 64'h8000_0000_0000_0000 || t !== 4'd5) begin tests_failed++; $display("[TB] FAIL flags_result: C=%h tag=%0d want 8000000000000000/5", c, t); end
        tests_run++; if (f !== 4'b0011) begin tests_failed++; $display("[TB] FAIL flags_value: flags=%b want 0011", f); end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] c;
        logic [3:0]  f;
        logic [3:0]  t;
        int          lat;
        bit          to;
        int          waited;
        do_reset();
        run_op(1, 64'd1, 64'd1, 4'd0, 4'd0, 4'd1, c, f, t, lat, to);
        set_req(0, 64'd11, 64'd22, 4'd0, 4'd0, 4'd3);
        req_valid = 2'b01;
        @(posedge clk); @(negedge clk);
        #1;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL midop_issue_busy: busy=%b want 1", busy); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0 || alu_in1 !== 64'd0 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL midop_issue_reset: busy=%b alu_in1=%0d req_ready=%b rsp_valid=%b want all 0", busy, alu_in1, req_ready, rsp_valid); end
        tests_run++; if (op_count1 !== 4'd0 || op_count0 !== 4'd0) begin tests_failed++; $display("[TB] FAIL midop_issue_counts: cnt0=%0d cnt1=%0d want 0/0", op_count0, op_count1); end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        req_valid = 2'b01;
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00;
        #1;
        waited = 0;
        while (!rsp_valid[0] && waited < 10) begin @(negedge clk); #1; waited++; end
        tests_run++; if (rsp_valid !== 2'b01 || rsp_C !== 64'd33) begin tests_failed++; $display("[TB] FAIL midop_resp_before: rsp_valid=%b C=%0d want 01/33", rsp_valid, rsp_C); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (rsp_valid !== 2'b00 || rsp_C !== 64'd0 || rsp_tag !== 4'd0 || rsp_flags !== 4'd0) begin tests_failed++; $display("[TB] FAIL midop_resp_reset: rsp_valid=%b C=%0d tag=%0d flags=%b want 0", rsp_valid, rsp_C, rsp_tag, rsp_flags); end
        tests_run++; if (op_count0 !== 4'd0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midop_resp_state: cnt0=%0d busy=%b want 0/0", op_count0, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_op(0, 64'd10, 64'd20, 4'd0, 4'd0, 4'd7, c, f, t, lat, to);
        tests_run++; if (to !== 1'b0 || c !== 64'd30 || t !== 4'd7) begin tests_failed++; $display("[TB] FAIL midop_after: timeout=%b C=%0d tag=%0d want 0/30/7", to, c, t); end
        tests_run++; if (op_count0 !== 4'd1) begin tests_failed++; $display("[TB] FAIL midop_after_count: cnt0=%0d want 1", op_count0); end
    endtask

    task automatic test_counter_wrap();
        logic [63:0] c;
        logic [3:0]  f;
        logic [3:0]  t;
        int          lat;
        int          timeouts;
        bit          to;
        do_reset();
        timeouts = 0;
        for (int i = 0; i < 17; i++) begin
            run_op(0, 64'(i), 64'(i), 4'd0, 4'd0, 4'(i), c, f, t, lat, to);
            if (to) timeouts++;
        end
        tests_run++; if (timeouts !== 0) begin tests_failed++; $display("[TB] FAIL wrap_timeouts: got %0d want 0", timeouts); end
        tests_run++; if (op_count0 !== 4'd1 || op_count1 !== 4'd0) begin tests_failed++; $display("[TB] FAIL wrap_counts: cnt0=%0d cnt1=%0d want 1/0", op_count0, op_count1); end
    endtask

    task automatic test_random();
        bit          pending;
        int          owner;
        int          age;
        int          tie_winner;
        int          winner;
        int          done[2];
        logic [67:0] expected;
        logic [3:0]  exp_tag;
        logic [1:0]  exp_grant;
        do_reset();
        pending = 1'b0; owner = 0; age = 0; tie_winner = 0;
        done[0] = 0; done[1] = 0;
        expected = '0; exp_tag = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_in1   = {$urandom, $urandom, $urandom, $urandom};
            req_in2   = {$urandom, $urandom, $urandom, $urandom};
            req_func3 = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
            req_func7 = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 1))};
            req_tag   = 8'($urandom);
            rsp_ready = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            #1;
            tests_run++; if (op_count0 !== 4'(done[0]) || op_count1 !== 4'(done[1])) begin tests_failed++; $display("[TB] FAIL rand_counts@%0d: cnt0=%0d cnt1=%0d want %0d/%0d", cyc, op_count0, op_count1, done[0] % 16, done[1] % 16); end
            if (pending) begin
                age++;
                tests_run++; if (req_ready !== 2'b00 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand_busy@%0d: req_ready=%b busy=%b want 00/1", cyc, req_ready, busy); end
                tests_run++; if (rsp_valid !== ((age >= 2) ? (owner ? 2'b10 : 2'b01) : 2'b00)) begin tests_failed++; $display("[TB] FAIL rand_rsp_valid@%0d: got %b owner=%0d age=%0d", cyc, rsp_valid, owner, age); end
                if (age >= 2) begin
                    tests_run++; if (rsp_C !== expected[63:0] || rsp_flags !== expected[67:64] || rsp_tag !== exp_tag) begin tests_failed++; $display("[TB] FAIL rand_rsp@%0d: C=%h flags=%b tag=%h want %h/%b/%h", cyc, rsp_C, rsp_flags, rsp_tag, expected[63:0], expected[67:64], exp_tag); end
                    if (rsp_ready[owner]) begin
                        done[owner]++;
                        pending = 1'b0;
                    end
                end
            end else begin
                tests_run++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL rand_idle@%0d: busy=%b rsp_valid=%b want 0/00", cyc, busy, rsp_valid); end
                if (req_valid == 2'b00) winner = -1;
                else if (req_valid == 2'b11) winner = tie_winner;
                else winner = req_valid[1] ? 1 : 0;
                exp_grant = (winner < 0) ? 2'b00 : ((winner == 1) ? 2'b10 : 2'b01);
                tests_run++; if (req_ready !== exp_grant) begin tests_failed++; $display("[TB] FAIL rand_grant@%0d: req_ready=%b want %b", cyc, req_ready, exp_grant); end
                if (winner >= 0) begin
                    expected = alu_model(req_in1[winner*64 +: 64], req_in2[winner*64 +: 64],
                                         req_func3[winner*4 +: 4], req_func7[winner*4 +: 4]);
                    exp_tag    = req_tag[winner*4 +: 4];
                    owner      = winner;
                    age        = 0;
                    pending    = 1'b1;
                    tie_winner = 1 - winner;
                end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
    endtask

    // Run every scenario in order, then report.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req_valid    = 2'b00;
        rsp_ready    = 2'b00;
        req_in1      = '0;
        req_in2      = '0;
        req_func3    = '0;
        req_func7    = '0;
        req_tag      = '0;
        @(negedge clk);
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_flags();
        test_reset_mid_op();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
